// File: rtl/instruction_queue_register.sv
// Instruction register fed by a small prefetch FIFO of {pc, instruction} pairs.
// Fetch pushes entries; the control FSM pops the head into the IR with IRWrite.
module instruction_queue_register #(
    parameter int unsigned     DATA_W  = 32,
    parameter int unsigned     ADDR_W  = 32,
    parameter int unsigned     DEPTH   = 4,
    parameter logic [DATA_W-1:0] NOP_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fill_valid,
    output logic                       fill_ready,
    input  logic [DATA_W-1:0]          fill_instr,
    input  logic [ADDR_W-1:0]          fill_pc,
    input  logic                       ir_write,
    input  logic                       flush,
    output logic [DATA_W-1:0]          instruction_out,
    output logic [ADDR_W-1:0]          pc_out,
    output logic                       ir_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       underflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned EW = DATA_W + ADDR_W;

    logic [EW-1:0]     mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ir_valid_q, ir_valid_d;
    logic              underflow_q, underflow_d;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [EW-1:0]     head;

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign fill_ready = !full && !flush;
    assign push       = fill_valid && fill_ready;
    // An empty queue never bypasses a same-cycle push into the IR.
    assign pop        = ir_write && !empty && !flush;
    assign head       = mem_q[rd_ptr_q];

    // Next-state for pointers, occupancy and the held IR; flush wins over all.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        ir_valid_d  = ir_valid_q;
        underflow_d = 1'b0;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            ir_valid_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d   = rd_ptr_q + PW'(1);
                instr_d    = head[DATA_W-1:0];
                pc_d       = head[EW-1:DATA_W];
                ir_valid_d = 1'b1;
            end else if (ir_write) begin
                ir_valid_d  = 1'b0;
                underflow_d = 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Control and IR state, cleared immediately on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            instr_q     <= NOP_VAL;
            pc_q        <= '0;
            ir_valid_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            ir_valid_q  <= ir_valid_d;
            underflow_q <= underflow_d;
        end
    end

    // Entry storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {fill_pc, fill_instr};
        end
    end

    assign instruction_out = instr_q;
    assign pc_out          = pc_q;
    assign ir_valid        = ir_valid_q;
    assign count           = count_q;
    assign underflow       = underflow_q;

endmodule

// File: tb/tb_instruction_queue_register.sv
// Directed bench for instruction_queue_register: expected IR updates are queued
// at issue time and checked by a monitor one cycle after each ir_write edge.
module tb_instruction_queue_register;

    typedef struct {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        uf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fill_valid = 1'b0;
    logic        fill_ready;
    logic [31:0] fill_instr = '0;
    logic [31:0] fill_pc = '0;
    logic        ir_write = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;
    logic        ir_valid;
    logic [2:0]  count;
    logic        underflow;

    int tests = 0;
    int fails = 0;
    exp_t sb[$];

    instruction_queue_register #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(4), .NOP_VAL(32'h0)
    ) dut (
        .clk(clk), .rst(rst),
        .fill_valid(fill_valid), .fill_ready(fill_ready),
        .fill_instr(fill_instr), .fill_pc(fill_pc),
        .ir_write(ir_write), .flush(flush),
        .instruction_out(instruction_out), .pc_out(pc_out),
        .ir_valid(ir_valid), .count(count), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ir(input logic v, input logic [31:0] i,
                             input logic [31:0] p, input logic u);
        exp_t e;
        e.valid = v;
        e.instr = i;
        e.pc    = p;
        e.uf    = u;
        sb.push_back(e);
    endtask

    // Called at a negedge; applies inputs across one rising edge.
    task automatic step(input logic fv, input logic [31:0] fi,
                        input logic [31:0] fp, input logic iw,
                        input logic fl);
        fill_valid = fv;
        fill_instr = fi;
        fill_pc    = fp;
        ir_write   = iw;
        flush      = fl;
        @(negedge clk);
        fill_valid = 1'b0;
        ir_write   = 1'b0;
        flush      = 1'b0;
    endtask

    // Monitor: after each ir_write edge compare IR outputs with the scoreboard.
    always @(posedge clk) begin
        if (!rst && ir_write) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_empty: got ir_write with no expectation");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ir_valid", 64'(ir_valid), 64'(e.valid));
                chk("instr", 64'(instruction_out), 64'(e.instr));
                chk("pc", 64'(pc_out), 64'(e.pc));
                chk("underflow", 64'(underflow), 64'(e.uf));
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: asynchronous reset clears a loaded IR mid-cycle
        step(1'b1, 32'h12345678, 32'h0000_00F0, 1'b0, 1'b0);
        expect_ir(1'b1, 32'h12345678, 32'h0000_00F0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("pre_rst_ir", 64'(instruction_out), 64'h12345678);
        #2 rst = 1'b1;
        #1;
        chk("rst_ir", 64'(instruction_out), 64'h0);
        chk("rst_pc", 64'(pc_out), 64'h0);
        chk("rst_cnt", 64'(count), 64'h0);
        chk("rst_rdy", 64'(fill_ready), 64'h1);
        chk("rst_val", 64'(ir_valid), 64'h0);
        chk("rst_uf", 64'(underflow), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // 2: FIFO order
        step(1'b1, 32'h20080005, 32'h00, 1'b0, 1'b0);
        step(1'b1, 32'h21090001, 32'h04, 1'b0, 1'b0);
        step(1'b1, 32'h01095020, 32'h08, 1'b0, 1'b0);
        chk("ord_cnt3", 64'(count), 64'd3);
        expect_ir(1'b1, 32'h20080005, 32'h00, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("ord_cnt2", 64'(count), 64'd2);
        expect_ir(1'b1, 32'h21090001, 32'h04, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("ord_cnt1", 64'(count), 64'd1);
        expect_ir(1'b1, 32'h01095020, 32'h08, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("ord_cnt0", 64'(count), 64'd0);

        // 3: full queue refuses a push even in a pop cycle
        step(1'b1, 32'hA0A0_0000, 32'h100, 1'b0, 1'b0);
        step(1'b1, 32'hA0A0_0001, 32'h104, 1'b0, 1'b0);
        step(1'b1, 32'hA0A0_0002, 32'h108, 1'b0, 1'b0);
        step(1'b1, 32'hA0A0_0003, 32'h10C, 1'b0, 1'b0);
        chk("full_cnt", 64'(count), 64'd4);
        chk("full_rdy", 64'(fill_ready), 64'h0);
        expect_ir(1'b1, 32'hA0A0_0000, 32'h100, 1'b0);
        step(1'b1, 32'hDEAD_BEEF, 32'h1F0, 1'b1, 1'b0);
        chk("full_cnt3", 64'(count), 64'd3);
        chk("full_rdy1", 64'(fill_ready), 64'h1);
        expect_ir(1'b1, 32'hA0A0_0001, 32'h104, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        expect_ir(1'b1, 32'hA0A0_0002, 32'h108, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        expect_ir(1'b1, 32'hA0A0_0003, 32'h10C, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("full_drain", 64'(count), 64'd0);

        // 4: underflow with simultaneous push, no bypass
        expect_ir(1'b0, 32'hA0A0_0003, 32'h10C, 1'b1);
        step(1'b1, 32'hAAAA0001, 32'h200, 1'b1, 1'b0);
        chk("uf_cnt", 64'(count), 64'd1);
        expect_ir(1'b1, 32'hAAAA0001, 32'h200, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("uf_cnt0", 64'(count), 64'd0);

        // 5: flush beats push and pop
        step(1'b1, 32'hB000_0000, 32'h210, 1'b0, 1'b0);
        step(1'b1, 32'hB000_0001, 32'h214, 1'b0, 1'b0);
        step(1'b1, 32'hB000_0002, 32'h218, 1'b0, 1'b0);
        chk("fl_cnt3", 64'(count), 64'd3);
        expect_ir(1'b0, 32'hAAAA0001, 32'h200, 1'b0);
        step(1'b1, 32'hC000_0000, 32'h220, 1'b1, 1'b1);
        chk("fl_cnt0", 64'(count), 64'd0);
        step(1'b1, 32'hD000_0000, 32'h300, 1'b0, 1'b0);
        chk("fl_cnt1", 64'(count), 64'd1);
        expect_ir(1'b1, 32'hD000_0000, 32'h300, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // 6: pointer wrap with interleaved push/pop
        step(1'b1, 32'h1000_0000, 32'h400, 1'b0, 1'b0);
        step(1'b1, 32'h1000_0001, 32'h404, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            expect_ir(1'b1, 32'h1000_0000 + i, 32'h400 + 4 * i, 1'b0);
            step(1'b1, 32'h1000_0002 + i, 32'h408 + 4 * i, 1'b1, 1'b0);
            chk("wrap_cnt", 64'(count), 64'd2);
        end
        expect_ir(1'b1, 32'h1000_000A, 32'h428, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        expect_ir(1'b1, 32'h1000_000B, 32'h42C, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("wrap_cnt0", 64'(count), 64'd0);

        repeat (3) @(negedge clk);
        chk("sb_left", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
